uart_tx_record_formatter: RTL and testbench
===========================================

# uart_tx_record_formatter

Parametrised successor to the single-value UART text sender. It latches N_CH signed or unsigned integers of DATA_W bits and emits them as one ASCII decimal text record, e.g. "-1234,0,57\r\n". The bytes go to the existing UART_TX byte transmitter through its start/active handshake. It sits between the classifier result registers and UART_TX, and converts with a sequential double-dabble so timing does not depend on a wide combinational bin2bcd.

## Interface
- DATA_W, 16: bits per channel value; legal range 4..32.
- N_CH, 4: channels per record; legal range 1..16.
- SIGNED_MODE, 1: 1 = two's-complement values; 0 = unsigned.
- SEPARATOR, 8'h2C: byte emitted between channels (",").
- SEND_LF, 1: 1 = record ends CR LF; 0 = CR only.
- Derived localparam ND = (DATA_W*3+9)/10 + 1: decimal digits per value.
- Clk  in  1  system clock, all logic on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- i_Data  in  N_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]; channel 0 is sent first.
- i_Start  in  1  request to send one record.
- o_Busy  out  1  high from acceptance until the record completes.
- o_Done  out  1  one-cycle pulse when the record completes.
- o_Tx_Byte  out  8  byte to UART_TX.
- o_Tx_Start  out  1  one-cycle start pulse to UART_TX.
- i_Tx_Active  in  1  UART_TX busy flag.

## Operation
- Reset values: o_Busy=0, o_Done=0, o_Tx_Start=0, o_Tx_Byte=8'h00, FSM in IDLE, channel index 0.
- IDLE: i_Start=1 latches all of i_Data into a holding register and moves to LOAD. i_Start is ignored in every other state, so a mid-record change on i_Data has no effect.
- LOAD: select the current channel.
  - neg = SIGNED_MODE && msb.
  - Magnitude = neg ? two's-complement negate : value, held as DATA_W-bit unsigned. The most negative value is therefore correct, e.g. -32768 gives 32768.
  - Clear the BCD register (4*ND bits).
- CONV: DATA_W cycles of add-3-if-≥5 on every BCD digit, then shift left one bit with the magnitude MSB as input.
- SIGN: emit "-" (8'h2D) only if neg.
- DIGIT: walk digits from most significant to least.
  - Skip leading zeros.
  - Always emit the least significant digit, so zero sends "0".
  - Digit byte = 8'h30 + digit.
- SEP: emit SEPARATOR if this is not the last channel, increment the channel index, and go to LOAD.
- CR: emit 8'h0D.
- LF: emit 8'h0A, only when SEND_LF=1.
- FIN: pulse o_Done, clear the channel index, return to IDLE.
- Emit sub-handshake, identical for every byte:
  - Wait until i_Tx_Active=0.
  - Drive o_Tx_Byte and pulse o_Tx_Start for exactly one cycle.
  - Wait for i_Tx_Active=1 (WAIT_ACK), then for i_Tx_Active=0 (WAIT_DONE), before the next emit.
  - o_Tx_Byte is held stable from the start pulse until WAIT_DONE exits.
- Asynchronous reset mid-record: immediate return to reset values. No further bytes are emitted. A byte already inside UART_TX completes on its own.

## Timing
- i_Start sampled in IDLE at cycle t: o_Busy=1 from t+1.
- Per channel: 1 LOAD cycle + DATA_W CONV cycles before the first emit attempt.
- First o_Tx_Start no earlier than t+2+DATA_W when i_Tx_Active=0.
- o_Tx_Start is never high on two consecutive cycles.
- o_Tx_Start is never high while i_Tx_Active=1 or in WAIT_ACK.
- o_Done is high in the cycle after WAIT_DONE of the final terminator byte exits. o_Busy falls in that same cycle.
- i_Start is next accepted one cycle later.
- If i_Tx_Active never rises after a start pulse, the FSM stays in WAIT_ACK. This is intentional; there is no timeout.

## Test plan
- N_CH=2, DATA_W=16, signed, SEND_LF=1, i_Data={ch1=0, ch0=-1234}, UART model asserting Active 1 cycle after start for 10 cycles -> byte stream 2D 31 32 33 34 2C 30 0D 0A, one o_Done pulse, o_Busy low afterwards.
- Extremes at DATA_W=16: ch0=16'h8000 signed -> "-32768"; SIGNED_MODE=0, ch0=16'hFFFF -> "65535"; DATA_W=32 signed 32'h80000000 -> "-2147483648".
- Handshake stress: random Active delays 1..5 cycles and lengths 1..50 cycles -> checker confirms no o_Tx_Start during Active or WAIT_ACK, o_Tx_Byte stable per byte, byte order correct.
- i_Start pulsed and i_Data changed mid-record -> bytes reflect the originally latched values; no second record starts until after o_Done.
- Rst_n low for 1 cycle during the digit phase of channel 1 -> all outputs return to reset values within the reset cycle, no further o_Tx_Start. A fresh i_Start then sends a complete, correct record beginning at channel 0.
- SEND_LF=0, SEPARATOR=8'h3B, N_CH=3, values {7, 0, -5} -> bytes 37 3B 30 3B 2D 35 0D.

Source files
------------

// File: rtl/uart_tx_record_formatter.sv
// Formats N_CH latched integers as one ASCII decimal record ("-12,0,57\r\n") and
// feeds the bytes to UART_TX through its start/active handshake.
module uart_tx_record_formatter #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned N_CH        = 4,
    parameter bit          SIGNED_MODE = 1'b1,
    parameter logic [7:0]  SEPARATOR   = 8'h2C,
    parameter bit          SEND_LF     = 1'b1
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [N_CH*DATA_W-1:0]   i_Data,
    input  logic                     i_Start,
    output logic                     o_Busy,
    output logic                     o_Done,
    output logic [7:0]               o_Tx_Byte,
    output logic                     o_Tx_Start,
    input  logic                     i_Tx_Active
);

    localparam int unsigned ND    = (DATA_W*3+9)/10 + 1;
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_W = $clog2(DATA_W+1);
    localparam int unsigned DG_W  = $clog2(ND);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CONV, S_SIGN, S_DIGIT, S_SEP, S_CR, S_LF, S_FIN,
        S_EMIT, S_WAIT_ACK, S_WAIT_DONE
    } state_t;

    state_t                  state_q, state_d, ret_q, ret_d;
    logic [N_CH*DATA_W-1:0]  hold_q, hold_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [DATA_W-1:0]       mag_q, mag_d;
    logic [4*ND-1:0]         bcd_q, bcd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DG_W-1:0]         dig_q, dig_d;
    logic                    neg_q, neg_d;
    logic                    started_q, started_d;
    logic [7:0]              byte_q, byte_d;

    logic [DATA_W-1:0]       sel_val;
    logic [3:0]              cur_dig;
    logic [3:0]              nib;
    logic [4*ND-1:0]         bcd_adj;

    always_comb begin
        sel_val = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (ch_q == CH_W'(k)) sel_val = hold_q[k*DATA_W +: DATA_W];
        end
        cur_dig = '0;
        bcd_adj = '0;
        nib     = '0;
        for (int unsigned k = 0; k < ND; k++) begin
            if (dig_q == DG_W'(k)) cur_dig = bcd_q[k*4 +: 4];
            nib = bcd_q[k*4 +: 4];
            bcd_adj[k*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    // Byte-producing states load byte_d/ret_d and hand over to the shared
    // EMIT -> WAIT_ACK -> WAIT_DONE sequence, which returns to ret_q.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        hold_d     = hold_q;
        ch_d       = ch_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        dig_d      = dig_q;
        neg_d      = neg_q;
        started_d  = started_q;
        byte_d     = byte_q;
        o_Tx_Start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    hold_d  = i_Data;
                    ch_d    = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                neg_d   = SIGNED_MODE && sel_val[DATA_W-1];
                mag_d   = (SIGNED_MODE && sel_val[DATA_W-1]) ? -sel_val : sel_val;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = S_CONV;
            end
            S_CONV: begin
                bcd_d = (bcd_adj << 1) | {{(4*ND-1){1'b0}}, mag_q[DATA_W-1]};
                mag_d = mag_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W-1)) state_d = S_SIGN;
            end
            S_SIGN: begin
                dig_d     = DG_W'(ND-1);
                started_d = 1'b0;
                if (neg_q) begin
                    byte_d  = 8'h2D;
                    ret_d   = S_DIGIT;
                    state_d = S_EMIT;
                end else begin
                    state_d = S_DIGIT;
                end
            end
            S_DIGIT: begin
                if (cur_dig != 4'd0 || started_q || dig_q == '0) begin
                    byte_d    = 8'h30 + {4'h0, cur_dig};
                    started_d = 1'b1;
                    state_d   = S_EMIT;
                    if (dig_q == '0) begin
                        ret_d = S_SEP;
                    end else begin
                        ret_d = S_DIGIT;
                        dig_d = dig_q - 1'b1;
                    end
                end else begin
                    dig_d = dig_q - 1'b1;
                end
            end
            S_SEP: begin
                if (ch_q != CH_W'(N_CH-1)) begin
                    byte_d  = SEPARATOR;
                    ch_d    = ch_q + 1'b1;
                    ret_d   = S_LOAD;
                    state_d = S_EMIT;
                end else begin
                    state_d = S_CR;
                end
            end
            S_CR: begin
                byte_d  = 8'h0D;
                ret_d   = SEND_LF ? S_LF : S_FIN;
                state_d = S_EMIT;
            end
            S_LF: begin
                byte_d  = 8'h0A;
                ret_d   = S_FIN;
                state_d = S_EMIT;
            end
            S_FIN: begin
                ch_d    = '0;
                state_d = S_IDLE;
            end
            S_EMIT: begin
                if (!i_Tx_Active) begin
                    o_Tx_Start = 1'b1;
                    state_d    = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (i_Tx_Active) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!i_Tx_Active) state_d = ret_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            ret_q     <= S_IDLE;
            hold_q    <= '0;
            ch_q      <= '0;
            mag_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            dig_q     <= '0;
            neg_q     <= 1'b0;
            started_q <= 1'b0;
            byte_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            hold_q    <= hold_d;
            ch_q      <= ch_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            neg_q     <= neg_d;
            started_q <= started_d;
            byte_q    <= byte_d;
        end
    end

    assign o_Busy    = (state_q != S_IDLE) && (state_q != S_FIN);
    assign o_Done    = (state_q == S_FIN);
    assign o_Tx_Byte = byte_q;

endmodule

// File: tb/tb_uart_tx_record_formatter.sv
// Bench for uart_tx_record_formatter: four parameter variants, table vectors,
// random records against a string-based reference, and a handshake monitor.
module tb_uart_tx_record_formatter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] d0;
    logic [15:0] d1;
    logic [31:0] d2;
    logic [47:0] d3;
    logic [3:0]  start;
    logic [3:0]  act = '0;
    wire  [3:0]  st, dn, bsy;
    wire  [7:0]  byt [4];

    uart_tx_record_formatter #(.DATA_W(16), .N_CH(2), .SIGNED_MODE(1'b1), .SEPARATOR(8'h2C), .SEND_LF(1'b1)) u0 (
        .Clk(clk), .Rst_n(rst_n), .i_Data(d0), .i_Start(start[0]), .o_Busy(bsy[0]), .o_Done(dn[0]),
        .o_Tx_Byte(byt[0]), .o_Tx_Start(st[0]), .i_Tx_Active(act[0]));
    uart_tx_record_formatter #(.DATA_W(16), .N_CH(1), .SIGNED_MODE(1'b0), .SEPARATOR(8'h2C), .SEND_LF(1'b1)) u1 (
        .Clk(clk), .Rst_n(rst_n), .i_Data(d1), .i_Start(start[1]), .o_Busy(bsy[1]), .o_Done(dn[1]),
        .o_Tx_Byte(byt[1]), .o_Tx_Start(st[1]), .i_Tx_Active(act[1]));
    uart_tx_record_formatter #(.DATA_W(32), .N_CH(1), .SIGNED_MODE(1'b1), .SEPARATOR(8'h2C), .SEND_LF(1'b1)) u2 (
        .Clk(clk), .Rst_n(rst_n), .i_Data(d2), .i_Start(start[2]), .o_Busy(bsy[2]), .o_Done(dn[2]),
        .o_Tx_Byte(byt[2]), .o_Tx_Start(st[2]), .i_Tx_Active(act[2]));
    uart_tx_record_formatter #(.DATA_W(16), .N_CH(3), .SIGNED_MODE(1'b1), .SEPARATOR(8'h3B), .SEND_LF(1'b0)) u3 (
        .Clk(clk), .Rst_n(rst_n), .i_Data(d3), .i_Start(start[3]), .o_Busy(bsy[3]), .o_Done(dn[3]),
        .o_Tx_Byte(byt[3]), .o_Tx_Start(st[3]), .i_Tx_Active(act[3]));

    int unsigned dw  [4] = '{16, 16, 32, 16};
    int unsigned nch [4] = '{2, 1, 1, 3};
    bit          sgn [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit          lf  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]  sepc[4] = '{8'h2C, 8'h2C, 8'h2C, 8'h3B};

    int unsigned dly[4] = '{1, 1, 1, 1};
    int unsigned len[4] = '{10, 10, 10, 10};
    bit          rnd[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string name, longint got, longint want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
        end
    endfunction

    // Reference: each channel printed with %0d after sign interpretation.
    function automatic string model(int u, logic [63:0] data);
        string  s;
        longint raw;
        s = "";
        for (int k = 0; k < int'(nch[u]); k++) begin
            raw = longint'((data >> (k*dw[u])) & ((64'd1 << dw[u]) - 64'd1));
            if (sgn[u] && raw[dw[u]-1]) raw = raw - (longint'(1) << dw[u]);
            s = {s, $sformatf("%0d", raw)};
            if (k < int'(nch[u]) - 1) s = {s, $sformatf("%c", sepc[u])};
        end
        s = {s, "\015"};
        if (lf[u]) s = {s, "\012"};
        return s;
    endfunction

    // UART_TX stand-in: Active rises dly cycles after a start and stays high len cycles.
    int unsigned dc[4];
    int unsigned lc[4];
    int unsigned dd, ll;
    always @(posedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (st[u]) begin
                dd = rnd[u] ? $urandom_range(1, 5)  : dly[u];
                ll = rnd[u] ? $urandom_range(1, 50) : len[u];
                lc[u] = ll;
                if (dd <= 1) act[u] <= 1'b1;
                else         dc[u] = dd - 1;
            end else if (dc[u] > 0) begin
                dc[u]--;
                if (dc[u] == 0) act[u] <= 1'b1;
            end else if (lc[u] > 0 && act[u]) begin
                lc[u]--;
                if (lc[u] == 0) act[u] <= 1'b0;
            end
        end
    end

    logic [7:0] cap[$];
    int         ndone;
    int         phase  [4] = '{0, 0, 0, 0};
    bit         prev_st[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] held   [4];

    always @(negedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (st[u]) cap.push_back(byt[u]);
            if (dn[u]) ndone++;
            if (!rst_n) begin
                phase[u]   = 0;
                prev_st[u] = 1'b0;
            end else begin
                if (st[u]) begin
                    chk("start_legal{act,pending,prev}", {act[u], phase[u] != 0, prev_st[u]}, 0);
                    phase[u] = 1;
                    held[u]  = byt[u];
                end else if (phase[u] == 1 && act[u]) begin
                    phase[u] = 2;
                end else if (phase[u] == 2 && !act[u]) begin
                    phase[u] = 0;
                end
                if (phase[u] != 0 && !st[u]) chk("byte_stable", byt[u], held[u]);
                prev_st[u] = st[u];
            end
        end
    end

    task automatic drive(input int u, input logic [63:0] data);
        case (u)
            0: d0 = data[31:0];
            1: d1 = data[15:0];
            2: d2 = data[31:0];
            default: d3 = data[47:0];
        endcase
    endtask

    task automatic run_rec(input int u, input logic [63:0] data, input string exp, input string nm, input bit midchg);
        int cyc;
        int nbytes;
        cap.delete();
        ndone = 0;
        @(negedge clk);
        drive(u, data);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        chk({nm, "_busy"}, bsy[u], 1);
        cyc = 0;
        while (ndone == 0 && cyc < 20000) begin
            if (midchg && cyc == 30) begin
                drive(u, ~data);
                start[u] = 1'b1;
            end else if (midchg && cyc == 31) begin
                start[u] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        repeat (midchg ? 40 : 3) @(negedge clk);
        chk({nm, "_done_pulses"}, ndone, 1);
        chk({nm, "_busy_after"}, bsy[u], 0);
        nbytes = cap.size();
        chk({nm, "_nbytes"}, nbytes, exp.len());
        for (int i = 0; i < exp.len(); i++)
            chk({nm, "_byte"}, (i < nbytes) ? longint'(cap[i]) : -1, longint'(exp[i]));
    endtask

    typedef struct {
        int          u;
        logic [63:0] data;
        string       exp;
        string       nm;
    } vec_t;
    vec_t tbl[$];

    initial begin
        int cyc;
        int u;
        logic [63:0] rd;
        rst_n = 1'b0;
        start = '0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;

        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("reset_busy", bsy[i], 0);
            chk("reset_done", dn[i], 0);
            chk("reset_start", st[i], 0);
            chk("reset_byte", byt[i], 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back('{0, 64'h0000_FB2E, "-1234,0\015\012",          "neg1234"});
        tbl.push_back('{0, 64'h8000_7FFF, "32767,-32768\015\012",     "s16_ext"});
        tbl.push_back('{0, 64'hFFFF_0009, "9,-1\015\012",             "s16_small"});
        tbl.push_back('{1, 64'h0000_FFFF, "65535\015\012",            "u16_max"});
        tbl.push_back('{1, 64'h0000_0000, "0\015\012",                "u16_zero"});
        tbl.push_back('{2, 64'h8000_0000, "-2147483648\015\012",      "s32_min"});
        tbl.push_back('{2, 64'h7FFF_FFFF, "2147483647\015\012",       "s32_max"});
        tbl.push_back('{3, 64'hFFFB_0000_0007, "7;0;-5\015",          "semi_nolf"});
        tbl.push_back('{3, 64'h0064_FF9C_000A, "10;-100;100\015",     "semi_mix"});
        foreach (tbl[i]) run_rec(tbl[i].u, tbl[i].data, tbl[i].exp, tbl[i].nm, 1'b0);

        run_rec(0, {32'h0, 16'd321, 16'd42}, "42,321\015\012", "midchg", 1'b1);

        // Reset while channel 1's digits are being sent.
        cap.delete();
        ndone = 0;
        @(negedge clk);
        d0 = {16'h1234, 16'd5};
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 0;
        while (cap.size() < 3 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reach_ch1", cap.size(), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", bsy[0], 0);
        chk("rst_mid_done", dn[0], 0);
        chk("rst_mid_start", st[0], 0);
        chk("rst_mid_byte", byt[0], 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("rst_no_more_bytes", cap.size(), 3);
        chk("rst_done_none", ndone, 0);
        run_rec(0, {32'h0, 16'hFFF6, 16'd8}, "8,-10\015\012", "after_rst", 1'b0);

        rnd = '{1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 16; i++) begin
            u  = $urandom_range(0, 3);
            rd = {$urandom, $urandom};
            run_rec(u, rd, model(u, rd), "rand", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
